// File: rtl/spram_fifo_if.sv
// Producer/consumer handshake plus SPRAM port bundle for spram_fifo_ctrl.
// Defining FIFO_LEVEL_EN adds the occupancy output "level".
interface spram_fifo_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
);
   logic                  push_valid;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  push_ready;
   logic                  pop_valid;
   logic [DATA_WIDTH-1:0] pop_data;
   logic                  pop_ready;
   logic                  full;
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef FIFO_LEVEL_EN
   logic [ADDR_WIDTH:0]   level;

   modport slave (
      input  push_valid, push_data, pop_ready, ram_rdata,
      output push_ready, pop_valid, pop_data, full,
             ram_en, ram_we, ram_addr, ram_wdata, level
   );

   modport master (
      output push_valid, push_data, pop_ready, ram_rdata,
      input  push_ready, pop_valid, pop_data, full,
             ram_en, ram_we, ram_addr, ram_wdata, level
   );
`else
   modport slave (
      input  push_valid, push_data, pop_ready, ram_rdata,
      output push_ready, pop_valid, pop_data, full,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output push_valid, push_data, pop_ready, ram_rdata,
      input  push_ready, pop_valid, pop_data, full,
             ram_en, ram_we, ram_addr, ram_wdata
   );
`endif
endinterface

// File: rtl/spram_fifo_ctrl.sv
// FIFO sequencer over one single-port RAM: arbitrates pushes vs head prefetch reads.
// Optional FIFO_LEVEL_EN adds a registered-state-derived occupancy output.
module spram_fifo_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   spram_fifo_if.slave bus
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WR   = 2'd1,
      GNT_RD   = 2'd2
   } gnt_e;

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  pop_valid_q, pop_valid_d;
   logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
   logic                  prio_q, prio_d;

   logic ram_empty;
   logic full;
   logic wr_want;
   logic rd_want;
   logic contested;
   gnt_e gnt;

   always_comb begin
      ram_empty = (rd_ptr_q == wr_ptr_q);
      full      = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
      // rst_n gating keeps push_ready/ram_en low while reset is held
      wr_want   = rst_n & bus.push_valid & ~full;
      rd_want   = rst_n & ~ram_empty & ~rd_pend_q & (~pop_valid_q | bus.pop_ready);
      contested = wr_want & rd_want;
      gnt       = GNT_NONE;
      if (contested) begin
         gnt = prio_q ? GNT_RD : GNT_WR;
      end else if (wr_want) begin
         gnt = GNT_WR;
      end else if (rd_want) begin
         gnt = GNT_RD;
      end
   end

   always_comb begin
      bus.push_ready = 1'b0;
      bus.ram_en     = 1'b0;
      bus.ram_we     = 1'b0;
      bus.ram_addr   = '0;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      rd_pend_d      = 1'b0;
      pop_valid_d    = pop_valid_q;
      pop_data_d     = pop_data_q;
      prio_d         = prio_q ^ contested;

      case (gnt)
         GNT_WR: begin
            bus.push_ready = 1'b1;
            bus.ram_en     = 1'b1;
            bus.ram_we     = 1'b1;
            bus.ram_addr   = wr_ptr_q[ADDR_WIDTH-1:0];
            wr_ptr_d       = wr_ptr_q + PTR_ONE;
         end
         GNT_RD: begin
            bus.ram_en     = 1'b1;
            bus.ram_addr   = rd_ptr_q[ADDR_WIDTH-1:0];
            rd_ptr_d       = rd_ptr_q + PTR_ONE;
            rd_pend_d      = 1'b1;
         end
         default: ;
      endcase

      // a read is only issued when the pop register is free by the capture edge
      if (rd_pend_q) begin
         pop_data_d  = bus.ram_rdata;
         pop_valid_d = 1'b1;
      end else if (pop_valid_q && bus.pop_ready) begin
         pop_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_pend_q   <= 1'b0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
         prio_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_pend_q   <= rd_pend_d;
         pop_valid_q <= pop_valid_d;
         pop_data_q  <= pop_data_d;
         prio_q      <= prio_d;
      end
   end

   assign bus.full      = full;
   assign bus.pop_valid = pop_valid_q;
   assign bus.pop_data  = pop_data_q;
   assign bus.ram_wdata = bus.push_data;

`ifdef FIFO_LEVEL_EN
   // words in RAM, plus one in flight, plus the pop register
   assign bus.level = (wr_ptr_q - rd_ptr_q) + PW'(rd_pend_q) + PW'(pop_valid_q);
`else
   // default build carries no occupancy output
`endif

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Self-checking bench for spram_fifo_ctrl: vector table, corner sequences and a
// randomized run against a queue-based transaction model of the FIFO.
module tb_spram_fifo_ctrl;
   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spram_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   spram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // behavioural single-port synchronous RAM
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata     <= mem[bus.ram_addr];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else             n_pass++;
   endfunction

   // transaction model: RAM contents as a queue, one in-flight slot, one head register
   logic [DW-1:0] m_ram [$];
   bit            m_infl;
   logic [DW-1:0] m_infl_d;
   bit            m_hv;
   logic [DW-1:0] m_hd;
   bit            m_prio;
   int            m_wr, m_rd;

   bit            s_acc, s_cont, s_wgnt;
   logic          s_pr, s_en, s_we, s_pv, s_full;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_pd;
   logic [AW:0]   s_lvl;
   logic [DW-1:0] pushed [$];
   logic [DW-1:0] popped [$];

   task automatic model_reset();
      m_ram.delete();
      m_infl = 0; m_infl_d = '0; m_hv = 0; m_hd = '0; m_prio = 0; m_wr = 0; m_rd = 0;
   endtask

   task automatic step();
      bit ww, rw, wg, rg, fe;
      logic [AW-1:0] ae;
      @(negedge clk);
      fe = (m_ram.size() == DEPTH);
      ww = bus.push_valid && !fe;
      rw = (m_ram.size() > 0) && !m_infl && (!m_hv || bus.pop_ready);
      wg = ww && (!rw || !m_prio);
      rg = rw && !wg;
      ae = wg ? AW'(m_wr % DEPTH) : (rg ? AW'(m_rd % DEPTH) : '0);
      chk("push_ready", bus.push_ready, wg);
      chk("ram_en",     bus.ram_en, wg | rg);
      chk("ram_we",     bus.ram_we, wg);
      chk("ram_addr",   bus.ram_addr, ae);
      chk("pop_valid",  bus.pop_valid, m_hv);
      chk("pop_data",   bus.pop_data, m_hd);
      chk("full",       bus.full, fe);
`ifdef FIFO_LEVEL_EN
      chk("level", bus.level, m_ram.size() + int'(m_infl) + int'(m_hv));
      s_lvl = bus.level;
`else
      s_lvl = '0;
`endif
      s_pr = bus.push_ready; s_en = bus.ram_en; s_we = bus.ram_we; s_addr = bus.ram_addr;
      s_pv = bus.pop_valid;  s_pd = bus.pop_data; s_full = bus.full;
      s_cont = ww && rw;
      s_wgnt = wg;
      s_acc  = bus.push_valid && bus.push_ready;
      if (s_acc) pushed.push_back(bus.push_data);
      if (bus.pop_valid && bus.pop_ready) popped.push_back(bus.pop_data);
      if (m_infl) begin
         m_hv = 1; m_hd = m_infl_d; m_infl = 0;
      end else if (m_hv && bus.pop_ready) begin
         m_hv = 0;
      end
      if (rg) begin m_infl = 1; m_infl_d = m_ram.pop_front(); m_rd++; end
      if (wg) begin m_ram.push_back(bus.push_data); m_wr++; end
      if (ww && rw) m_prio = !m_prio;
      @(posedge clk); #1;
   endtask

   task automatic set_in(bit pv, logic [DW-1:0] pd, bit prd);
      bus.push_valid = pv; bus.push_data = pd; bus.pop_ready = prd;
   endtask

   task automatic do_reset();
      set_in(0, '0, 0);
      #2 rst_n = 1'b0;
      model_reset();
      pushed.delete(); popped.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // async reset while busy: outputs drop immediately, FIFO is empty afterwards
   task automatic reset_check(string tag);
      bus.push_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_rst_pop_valid"},  bus.pop_valid, 0);
      chk({tag, "_rst_ram_en"},     bus.ram_en, 0);
      chk({tag, "_rst_full"},       bus.full, 0);
      chk({tag, "_rst_push_ready"}, bus.push_ready, 0);
      model_reset();
      pushed.delete(); popped.delete();
      set_in(0, '0, 1);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (4) step();
      chk({tag, "_post_rst_pop_valid"}, s_pv, 0);
      chk({tag, "_post_rst_popped"}, popped.size(), 0);
   endtask

   typedef struct {
      bit            pv;
      logic [DW-1:0] pd;
      bit            prd;
      bit            e_pr, e_en, e_we;
      logic [AW-1:0] e_addr;
      bit            e_pv;
      logic [DW-1:0] e_pd;
   } vec_t;

   vec_t vt [5];

   initial begin
      int idx, k;
      bus.ram_rdata = '0;
      set_in(0, '0, 0);

      // push 0xA5 into an idle FIFO and follow it to the pop register
      vt[0] = '{1, 8'hA5, 0, 1, 1, 1, 3'd0, 0, 8'h00};
      vt[1] = '{0, 8'h00, 0, 0, 1, 0, 3'd0, 0, 8'h00};
      vt[2] = '{0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'h00};
      vt[3] = '{0, 8'h00, 1, 0, 0, 0, 3'd0, 1, 8'hA5};
      vt[4] = '{0, 8'h00, 0, 0, 0, 0, 3'd0, 0, 8'hA5};
      do_reset();
      chk("reset_pop_valid", bus.pop_valid, 0);
      chk("reset_full", bus.full, 0);
      chk("reset_pop_data", bus.pop_data, 0);
      for (int i = 0; i < 5; i++) begin
         set_in(vt[i].pv, vt[i].pd, vt[i].prd);
         step();
         chk($sformatf("vec%0d_push_ready", i), s_pr, vt[i].e_pr);
         chk($sformatf("vec%0d_ram_en", i), s_en, vt[i].e_en);
         chk($sformatf("vec%0d_ram_we", i), s_we, vt[i].e_we);
         chk($sformatf("vec%0d_ram_addr", i), s_addr, vt[i].e_addr);
         chk($sformatf("vec%0d_pop_valid", i), s_pv, vt[i].e_pv);
         chk($sformatf("vec%0d_pop_data", i), s_pd, vt[i].e_pd);
      end

      // fill with no pops: DEPTH in RAM plus one in the pop register
      do_reset();
      idx = 0;
      for (int c = 0; c < 30; c++) begin
         set_in(idx < 10, DW'(idx), 0);
         step();
         if (s_acc) idx++;
      end
      chk("fill_accepted", idx, 9);
      chk("fill_full", s_full, 1);
      chk("fill_push_ready_10th", s_pr, 0);
      chk("fill_pop_data", s_pd, 8'h00);
`ifdef FIFO_LEVEL_EN
      chk("fill_level", s_lvl, 9);
`endif
      reset_check("full");

      // continuous push and pop: contested cycles must alternate W, R, W, ...
      do_reset();
      idx = 0; k = 0;
      for (int c = 0; c < 12; c++) begin
         set_in(1, DW'(idx), 1);
         step();
         if (s_acc) idx++;
         if (s_cont) begin
            chk($sformatf("contest%0d_winner_is_write", k), s_wgnt, (k % 2) == 0);
            k++;
         end
      end
      chk("contest_count_min", k >= 4, 1);
      for (int i = 0; i < popped.size(); i++) chk($sformatf("stream_pop%0d", i), popped[i], DW'(i));
      reset_check("inflight");

      // 20 words through with random back-pressure, pointers wrap
      do_reset();
      idx = 0;
      for (int c = 0; c < 2000 && popped.size() < 20; c++) begin
         set_in(idx < 20, DW'(idx), 1'($urandom_range(0, 1)));
         step();
         if (s_acc) idx++;
      end
      chk("wrap_pop_count", popped.size(), 20);
      for (int i = 0; i < popped.size(); i++) chk($sformatf("wrap_pop%0d", i), popped[i], DW'(i));

      // free-running random traffic against the model and an order scoreboard
      do_reset();
      for (int c = 0; c < 400; c++) begin
         set_in(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) != 0));
         step();
      end
      set_in(0, '0, 1);
      repeat (30) step();
      chk("rand_all_popped", popped.size(), pushed.size());
      for (int i = 0; i < popped.size() && i < pushed.size(); i++)
         if (popped[i] !== pushed[i]) chk($sformatf("rand_order%0d", i), popped[i], pushed[i]);

`ifdef FIFO_LEVEL_EN
      do_reset();
      idx = 0;
      for (int c = 0; c < 20 && idx < 3; c++) begin
         set_in(1, DW'(idx), 0);
         step();
         if (s_acc) idx++;
      end
      set_in(0, '0, 0);
      repeat (4) step();
      chk("level_three", s_lvl, 3);
      set_in(0, '0, 1);
      step();
      set_in(0, '0, 0);
      repeat (4) step();
      chk("level_two", s_lvl, 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
